fetch_prefetch: RTL and testbench

- Parametrised successor to the single-instruction Fetch stage.
- Adds a DEPTH-entry prefetch queue between instruction memory and the IF/ID register.
- Memory side uses a variable-latency request/valid handshake.
- Supports the same four redirect sources, selected by Decode, and flushes in-flight and queued instructions on a redirect.

---
 rtl/fetch_prefetch.sv | 96 +++++++++
 tb/tb_fetch_prefetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: fetch stage with a DEPTH-entry prefetch queue and a variable-latency memory handshake.
module fetch_prefetch #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(64),
  parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_if_stall,
  input  logic               fw_if_id_stall,
  input  logic               id_if_selfontepc,
  input  logic [1:0]         id_if_seltipopc,
  input  logic [ADDR_W-1:0]  id_if_rega,
  input  logic [ADDR_W-1:0]  id_if_pcimd2ext,
  input  logic [ADDR_W-1:0]  id_if_pcindex,
  output logic               if_gdm_en,
  output logic [ADDR_W-1:0]  if_gdm_addr,
  input  logic               gdm_if_valid,
  input  logic [INSTR_W-1:0] gdm_if_data,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instrucao,
  output logic [ADDR_W-1:0]  if_id_proximopc
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d, req_addr_q, req_addr_d, target, cur_addr;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0] count_q, count_d;
  logic [ADDR_W-1:0] qpc_q [DEPTH];
  logic [INSTR_W-1:0] qins_q [DEPTH];
  logic id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic stall, redirect, en, enq, deq, pending;
  always_comb begin
    stall = ex_if_stall | fw_if_id_stall;
    redirect = id_if_selfontepc & ~stall;
    target = id_if_seltipopc == 2'd0 ? id_if_pcimd2ext :
             id_if_seltipopc == 2'd1 ? id_if_rega :
             id_if_seltipopc == 2'd2 ? id_if_pcindex : EXC_VEC;
    cur_addr = state_q == IDLE ? fpc_q : req_addr_q;
    en = ~reset & (state_q != IDLE | count_q < FULL);
    enq = en & gdm_if_valid & (state_q != DROP) & ~redirect;
    deq = ~stall & ~redirect & (count_q != '0);
    pending = en & ~gdm_if_valid;
    // an unanswered request survives a redirect only as a response to be thrown away
    state_d = ~pending ? IDLE : (state_q == DROP | redirect) ? DROP : WAIT;
    fpc_d = redirect ? target : enq ? fpc_q + PC_STEP : fpc_q;
    req_addr_d = cur_addr;
    count_d = redirect ? '0 : count_q + (PW+1)'(enq) - (PW+1)'(deq);
    wptr_d = redirect ? '0 : wptr_q + PW'(enq);
    rptr_d = redirect ? '0 : rptr_q + PW'(deq);
    id_valid_d = stall ? id_valid_q : deq;
    id_instr_d = stall ? id_instr_q : deq ? qins_q[rptr_q] : '0;
    id_pc_d = stall ? id_pc_q : deq ? qpc_q[rptr_q] : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      req_addr_q <= req_addr_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q <= id_pc_d;
    end
  end
  always_ff @(posedge clock) begin
    if (enq) begin
      qpc_q[wptr_q] <= cur_addr + PC_STEP;
      qins_q[wptr_q] <= gdm_if_data;
    end
  end
  assign if_gdm_en = en;
  assign if_gdm_addr = reset ? '0 : cur_addr;
  assign if_id_valid = id_valid_q;
  assign if_id_instrucao = id_instr_q;
  assign if_id_proximopc = id_pc_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_fetch_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] XD = 32'h5A5A_0000;
  logic clock = 0, reset = 1, ex_if_stall = 0, fw_if_id_stall = 0, id_if_selfontepc = 0;
  logic [1:0] id_if_seltipopc = 0;
  logic [31:0] id_if_rega = 0, id_if_pcimd2ext = 0, id_if_pcindex = 0;
  logic if_gdm_en, gdm_if_valid, if_id_valid;
  logic [31:0] if_gdm_addr, gdm_if_data, if_id_instrucao, if_id_proximopc;
  int lat = 0, wcnt = 0, checks = 0, errors = 0;
  bit chk_on = 0, rnd = 0;

  assign gdm_if_valid = if_gdm_en && (wcnt >= lat);
  assign gdm_if_data = if_gdm_addr ^ XD;
  always #5 clock = ~clock;

  fetch_prefetch #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ex_if_stall(ex_if_stall), .fw_if_id_stall(fw_if_id_stall),
    .id_if_selfontepc(id_if_selfontepc), .id_if_seltipopc(id_if_seltipopc), .id_if_rega(id_if_rega),
    .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_pcindex(id_if_pcindex), .if_gdm_en(if_gdm_en),
    .if_gdm_addr(if_gdm_addr), .gdm_if_valid(gdm_if_valid), .gdm_if_data(gdm_if_data),
    .if_id_valid(if_id_valid), .if_id_instrucao(if_id_instrucao), .if_id_proximopc(if_id_proximopc));

  // Reference: fetched words live in a queue; one request may be outstanding, live or doomed.
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t pq[$];
  logic [31:0] m_fpc, m_req, m_ipc, m_ins;
  bit m_iv;
  int m_out;

  function automatic bit m_en();
    return !reset && (m_out != 0 || pq.size() < DEPTH);
  endfunction
  function automatic logic [31:0] m_addr();
    return m_out != 0 ? m_req : m_fpc;
  endfunction

  task automatic model_edge(input bit rst, stl, sel_on, input logic [31:0] tgt,
                            input bit en, vld, input logic [31:0] a, d);
    bit redir;
    ent_t e;
    if (rst) begin
      pq.delete(); m_fpc = 0; m_req = 0; m_out = 0; m_iv = 0; m_ins = 0; m_ipc = 0;
      return;
    end
    redir = sel_on && !stl;
    if (!stl) begin
      if (!redir && pq.size() > 0) begin
        e = pq.pop_front(); m_iv = 1; m_ipc = e.pc; m_ins = e.ins;
      end else begin
        m_iv = 0; m_ipc = 0; m_ins = 0;
      end
    end
    if (en && vld) begin
      if (m_out != 2 && !redir) begin
        pq.push_back('{a + 32'd4, d});
        m_fpc = m_fpc + 32'd4;
      end
      m_out = 0;
    end else if (en) begin
      m_out = (m_out == 2 || redir) ? 2 : 1;
      m_req = a;
    end
    if (redir) begin
      m_fpc = tgt;
      pq.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    bit men, vs, rs, es;
    logic [31:0] ma, ds, tgt;
    @(negedge clock);
    if (chk_on) begin
      chk("m_gdm_en", if_gdm_en, m_en());
      if (m_en()) chk("m_gdm_addr", if_gdm_addr, m_addr());
      chk("m_id_valid", if_id_valid, m_iv);
      chk("m_id_instr", if_id_instrucao, m_ins);
      chk("m_id_pc", if_id_proximopc, m_ipc);
    end
    men = m_en(); ma = m_addr(); vs = gdm_if_valid; ds = ma ^ XD; rs = reset; es = if_gdm_en;
    tgt = id_if_seltipopc == 0 ? id_if_pcimd2ext : id_if_seltipopc == 1 ? id_if_rega :
          id_if_seltipopc == 2 ? id_if_pcindex : 32'd64;
    @(posedge clock);
    model_edge(rs, ex_if_stall | fw_if_id_stall, id_if_selfontepc, tgt, men, vs, ma, ds);
    chk_on = chk_on | rs;
    #1;
    wcnt = (rs || !es || vs) ? 0 : wcnt + 1;
    if (rnd && vs) lat = $urandom_range(0, 3);
  endtask

  task automatic do_reset();
    reset = 1; ex_if_stall = 0; fw_if_id_stall = 0; id_if_selfontepc = 0;
    cyc();
    reset = 0;
  endtask

  typedef struct {bit stl; bit rd; logic [1:0] sel; logic [31:0] rega;
                  bit e_en; logic [31:0] e_addr; bit e_v; logic [31:0] e_pc;} vec_t;
  vec_t tbl[15];
  logic [31:0] tg[4];
  logic [1:0] sl[4];

  initial begin
    tbl = '{
      '{0,0,0,0,   1,0,  0,0},  '{0,0,0,0,   1,4,  0,0},  '{0,0,0,0,   1,8,  1,4},
      '{1,0,0,0,   1,12, 1,8},  '{1,0,0,0,   1,16, 1,8},  '{1,0,0,0,   1,20, 1,8},
      '{1,0,0,0,   0,0,  1,8},  '{1,0,0,0,   0,0,  1,8},  '{0,0,0,0,   0,0,  1,8},
      '{0,0,0,0,   1,24, 1,12}, '{0,0,0,0,   1,28, 1,16}, '{0,1,1,100, 1,32, 1,20},
      '{0,0,0,0,   1,100,0,0},  '{0,0,0,0,   1,104,0,0},  '{0,0,0,0,   1,108,1,104}};
    reset = 1;
    cyc(); cyc();
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      ex_if_stall = tbl[i].stl; id_if_selfontepc = tbl[i].rd;
      id_if_seltipopc = tbl[i].sel; id_if_rega = tbl[i].rega;
      #1;
      chk("t_en", if_gdm_en, tbl[i].e_en);
      if (tbl[i].e_en) chk("t_addr", if_gdm_addr, tbl[i].e_addr);
      chk("t_valid", if_id_valid, tbl[i].e_v);
      chk("t_pc", if_id_proximopc, tbl[i].e_pc);
      chk("t_instr", if_id_instrucao, tbl[i].e_v ? (tbl[i].e_pc - 32'd4) ^ XD : 32'd0);
      cyc();
    end
    ex_if_stall = 0; id_if_selfontepc = 0;

    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1; chk("lat_en", if_gdm_en, 1); chk("lat_addr", if_gdm_addr, 0);
      cyc();
    end
    #1; chk("lat_next_addr", if_gdm_addr, 4); chk("lat_bubble", if_id_valid, 0);
    cyc();
    #1; chk("lat_valid", if_id_valid, 1); chk("lat_pc", if_id_proximopc, 4);
    cyc();
    #1; chk("lat_bubble2", if_id_valid, 0); chk("lat_bubble2_instr", if_id_instrucao, 0);
    cyc();

    lat = 0;
    do_reset();
    cyc(); cyc();
    tg = '{100, 200, 300, 64}; sl = '{1, 0, 2, 3};
    id_if_rega = 100; id_if_pcimd2ext = 200; id_if_pcindex = 300;
    for (int i = 0; i < 4; i++) begin
      id_if_seltipopc = sl[i]; id_if_selfontepc = 1;
      cyc();
      id_if_selfontepc = 0;
      #1; chk("rd_addr", if_gdm_addr, tg[i]); chk("rd_en", if_gdm_en, 1);
      chk("rd_bubble", if_id_valid, 0);
      cyc(); cyc();
    end

    lat = 2;
    do_reset();
    cyc();
    id_if_seltipopc = 3; id_if_selfontepc = 1;
    #1; chk("drop_addr_old", if_gdm_addr, 0);
    cyc();
    id_if_selfontepc = 0;
    #1; chk("drop_en", if_gdm_en, 1); chk("drop_addr", if_gdm_addr, 0);
    cyc();
    #1; chk("drop_target", if_gdm_addr, 64); chk("drop_no_stale", if_id_valid, 0);
    repeat (8) cyc();

    lat = 0;
    do_reset();
    repeat (4) cyc();
    lat = 3;
    cyc(); cyc();
    reset = 1;
    #1; chk("rst_en", if_gdm_en, 0); chk("rst_addr", if_gdm_addr, 0);
    cyc();
    chk("rst_valid", if_id_valid, 0); chk("rst_instr", if_id_instrucao, 0);
    chk("rst_pc", if_id_proximopc, 0);
    reset = 0; lat = 0;
    id_if_seltipopc = 1; id_if_rega = 32'hFFFF_FFFC; id_if_selfontepc = 1;
    #1; chk("rst_first_addr", if_gdm_addr, 0); chk("rst_first_en", if_gdm_en, 1);
    cyc();
    id_if_selfontepc = 0;
    #1; chk("wrap_addr_hi", if_gdm_addr, 32'hFFFF_FFFC);
    cyc();
    #1; chk("wrap_addr_0", if_gdm_addr, 0);
    cyc();
    #1; chk("wrap_valid", if_id_valid, 1); chk("wrap_pc", if_id_proximopc, 0);
    chk("wrap_instr", if_id_instrucao, 32'hFFFF_FFFC ^ XD);
    cyc();

    rnd = 1; lat = $urandom_range(0, 3);
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      ex_if_stall = ($urandom_range(0, 4) == 0);
      fw_if_id_stall = ($urandom_range(0, 6) == 0);
      id_if_selfontepc = ($urandom_range(0, 7) == 0);
      id_if_seltipopc = 2'($urandom_range(0, 3));
      id_if_rega = $urandom & ~32'd3;
      id_if_pcimd2ext = $urandom & ~32'd3;
      id_if_pcindex = $urandom & ~32'd3;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
